// File: rtl/gsm_lpc_mac_acc.sv
// GSM LPC multiply-accumulate: saturating frame sum of upstream products.
// One result per frame, held until the downstream handshake.
module gsm_lpc_mac_acc #(
  parameter int SHIFT_EN = 1,
  parameter int MAX_LEN  = 160
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [30:0] p_in,
  input  logic        p_valid,
  input  logic        p_last,
  output logic        p_ready,
  output logic [31:0] acc_out,
  output logic        acc_valid,
  input  logic        acc_ready,
  output logic        acc_sat,
  output logic        len_err
);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  localparam logic [7:0] LEN = 8'(MAX_LEN);

  state_t      state;
  logic [31:0] acc;
  logic [7:0]  cnt;

  logic [31:0] term;
  logic        term_sat;
  logic [32:0] sum;
  logic [31:0] sat_sum;
  logic        add_hi;
  logic        add_lo;
  logic [7:0]  cnt_nxt;
  logic        take;
  logic        close;

  assign p_ready = (state == ACC) & ~ap_rst;

  // L_MULT doubling; the one overflowing product clamps to max positive
  always_comb begin
    term     = {p_in[30], p_in};
    term_sat = 1'b0;
    if (SHIFT_EN != 0) begin
      if (p_in == 31'h4000_0000) begin
        term     = 32'h7FFF_FFFF;
        term_sat = 1'b1;
      end else begin
        term = {p_in, 1'b0};
      end
    end
  end

  assign sum    = {acc[31], acc} + {term[31], term};
  assign add_hi = ~sum[32] & sum[31];
  assign add_lo = sum[32] & ~sum[31];

  always_comb begin
    sat_sum = sum[31:0];
    if (add_hi)
      sat_sum = 32'h7FFF_FFFF;
    else if (add_lo)
      sat_sum = 32'h8000_0000;
  end

  assign cnt_nxt = cnt + 8'd1;
  assign take    = p_valid & p_ready;
  assign close   = take & (p_last | (cnt_nxt == LEN));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      acc_sat   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (take) begin
            acc <= sat_sum;
            cnt <= cnt_nxt;
            if (term_sat | add_hi | add_lo)
              acc_sat <= 1'b1;
          end
          if (close) begin
            acc_out   <= sat_sum;
            acc_valid <= 1'b1;
            len_err   <= ~p_last;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            acc_sat   <= 1'b0;
            len_err   <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_gsm_lpc_mac_acc.sv
// Directed bench for gsm_lpc_mac_acc (SHIFT_EN=1, MAX_LEN=4).
// Expected values are hand-computed constants.
module tb_gsm_lpc_mac_acc;

  logic        ap_clk;
  logic        ap_rst;
  logic [30:0] p_in;
  logic        p_valid;
  logic        p_last;
  logic        p_ready;
  logic [31:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        acc_sat;
  logic        len_err;

  int checks;
  int errors;

  gsm_lpc_mac_acc #(
    .SHIFT_EN(1),
    .MAX_LEN (4)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .p_in     (p_in),
    .p_valid  (p_valid),
    .p_last   (p_last),
    .p_ready  (p_ready),
    .acc_out  (acc_out),
    .acc_valid(acc_valid),
    .acc_ready(acc_ready),
    .acc_sat  (acc_sat),
    .len_err  (len_err)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [30:0] v, input logic last);
    p_in    = v;
    p_valid = 1'b1;
    p_last  = last;
    tick();
    p_valid = 1'b0;
    p_last  = 1'b0;
  endtask

  task automatic consume();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ap_rst    = 1'b1;
    p_in      = '0;
    p_valid   = 1'b0;
    p_last    = 1'b0;
    acc_ready = 1'b0;

    tick();
    tick();
    check("rst_p_ready", 32'(p_ready), 32'd0);
    check("rst_valid", 32'(acc_valid), 32'd0);
    check("rst_out", acc_out, 32'd0);
    check("rst_sat", 32'(acc_sat), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    ap_rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(p_ready), 32'd1);

    // 2*(100+200-50)
    send(31'd100, 1'b0);
    send(31'd200, 1'b0);
    check("basic_no_early_valid", 32'(acc_valid), 32'd0);
    send(-31'sd50, 1'b1);
    check("basic_valid", 32'(acc_valid), 32'd1);
    check("basic_out", acc_out, 32'd500);
    check("basic_sat", 32'(acc_sat), 32'd0);
    check("basic_len_err", 32'(len_err), 32'd0);
    check("basic_hold_ready", 32'(p_ready), 32'd0);
    consume();
    check("hs_valid_low", 32'(acc_valid), 32'd0);
    check("hs_ready_back", 32'(p_ready), 32'd1);

    send(31'h4000_0000, 1'b1);
    check("lmult_out", acc_out, 32'h7FFF_FFFF);
    check("lmult_sat", 32'(acc_sat), 32'd1);
    consume();
    check("lmult_sat_clr", 32'(acc_sat), 32'd0);

    send(31'h3FFF_FFFF, 1'b0);
    send(31'h3FFF_FFFF, 1'b1);
    check("addhi_out", acc_out, 32'h7FFF_FFFF);
    check("addhi_sat", 32'(acc_sat), 32'd1);
    consume();

    send(31'h4000_0001, 1'b0);
    send(31'h4000_0001, 1'b1);
    check("addlo_out", acc_out, 32'h8000_0000);
    check("addlo_sat", 32'(acc_sat), 32'd1);
    consume();

    // result held under backpressure; offered terms ignored in HOLD
    send(31'd5, 1'b1);
    p_in    = 31'd999;
    p_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out", acc_out, 32'd10);
      check("bp_valid", 32'(acc_valid), 32'd1);
      check("bp_ready", 32'(p_ready), 32'd0);
    end
    // term offered on the handshake cycle must be dropped
    p_in      = 31'd1000;
    p_last    = 1'b1;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    p_valid   = 1'b0;
    p_last    = 1'b0;
    check("bp_hs_valid", 32'(acc_valid), 32'd0);

    send(31'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid", 32'(acc_valid), 32'd0);
    end
    send(31'd4, 1'b1);
    check("after_bp_out", acc_out, 32'd14);
    check("after_bp_sat", 32'(acc_sat), 32'd0);
    consume();

    for (int i = 0; i < 3; i++) send(31'd1, 1'b0);
    check("len_not_yet", 32'(acc_valid), 32'd0);
    send(31'd1, 1'b0);
    check("len_valid", 32'(acc_valid), 32'd1);
    check("len_out", acc_out, 32'd8);
    check("len_err", 32'(len_err), 32'd1);
    check("len_sat", 32'(acc_sat), 32'd0);
    consume();
    check("len_err_clr", 32'(len_err), 32'd0);

    // reset mid-frame discards the partial sum
    send(31'd1, 1'b0);
    send(31'd1, 1'b0);
    ap_rst = 1'b1;
    tick();
    check("midrst_ready", 32'(p_ready), 32'd0);
    check("midrst_valid", 32'(acc_valid), 32'd0);
    ap_rst = 1'b0;
    tick();
    check("midrst_idle_valid", 32'(acc_valid), 32'd0);
    send(31'd6, 1'b1);
    check("midrst_out", acc_out, 32'd12);
    check("midrst_len_err", 32'(len_err), 32'd0);
    consume();

    // reset wins over a HOLD handshake and drops the pending result
    send(31'd9, 1'b1);
    ap_rst    = 1'b1;
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("holdrst_valid", 32'(acc_valid), 32'd0);
    check("holdrst_out", acc_out, 32'd0);
    ap_rst = 1'b0;
    tick();
    check("holdrst_after", 32'(acc_valid), 32'd0);
    send(31'd2, 1'b1);
    check("final_out", acc_out, 32'd4);
    check("final_valid", 32'(acc_valid), 32'd1);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsm_lpc_mac_acc.md
GSM_LPC_MAC_ACC -- requirements
Module: gsm_lpc_mac_acc

Interface
REQ-001 SHALL have parameter SHIFT_EN, default 1: when 1, each product is doubled with GSM L_MULT semantics; when 0, each product is sign-extended only.
REQ-002 SHALL have parameter MAX_LEN, default 160: maximum terms per frame, legal range 1..255.
REQ-003 SHALL have port ap_clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port p_in, input, 31 bits: signed 16x16 product from the upstream LPC multiplier.
REQ-006 SHALL have port p_valid, input, 1 bit: p_in/p_last valid.
REQ-007 SHALL have port p_last, input, 1 bit: final term of the current frame.
REQ-008 SHALL have port p_ready, output, 1 bit: block accepts a term this cycle.
REQ-009 SHALL have port acc_out, output, 32 bits: signed saturated frame sum.
REQ-010 SHALL have port acc_valid, output, 1 bit: acc_out/acc_sat/len_err valid.
REQ-011 SHALL have port acc_ready, input, 1 bit: downstream consumes the result.
REQ-012 SHALL have port acc_sat, output, 1 bit: saturation occurred anywhere in the frame.
REQ-013 SHALL have port len_err, output, 1 bit: frame closed by MAX_LEN without p_last.

Function
REQ-014 SHALL implement two states: ACC (accepting terms) and HOLD (presenting result).
REQ-015 SHALL drive p_ready = 1 only in ACC with ap_rst low; p_ready SHALL be 0 in HOLD.
REQ-016 SHALL accept a term only on a cycle with p_valid & p_ready; p_in is ignored otherwise.
REQ-017 SHALL form the 32-bit term for SHIFT_EN=1 as p_in shifted left 1, except p_in = 31'h4000_0000, which SHALL map to 32'h7FFF_FFFF and set the frame saturation flag.
REQ-018 SHALL form the 32-bit term for SHIFT_EN=0 as sign-extended p_in.
REQ-019 SHALL compute acc + term at 33-bit width and clamp to [32'h8000_0000, 32'h7FFF_FFFF]; any clamp SHALL set the sticky frame saturation flag.
REQ-020 SHALL keep an 8-bit term counter, cleared at frame start and incremented per accepted term.
REQ-021 SHALL close the frame on an accepted term carrying p_last=1, or on the accepted term that brings the counter to MAX_LEN; the MAX_LEN case without p_last SHALL set len_err.
REQ-022 SHALL, on frame close, register the final saturated sum (including the closing term) to acc_out, assert acc_valid on the next cycle, and enter HOLD.
REQ-023 SHALL accept a single-term frame (p_last on the first beat) with acc_out = that term.
REQ-024 SHALL hold acc_out, acc_sat, len_err and acc_valid stable in HOLD while acc_ready=0.
REQ-025 SHALL, on acc_valid & acc_ready, deassert acc_valid, clear acc, the counter, acc_sat and len_err, and return to ACC with p_ready=1 on the following cycle.
REQ-026 SHALL NOT accept any term on the same cycle as the HOLD->ACC handshake.
REQ-027 SHALL, with p_valid low in ACC, leave acc and the counter unchanged, with no timeout.

Reset
REQ-028 SHALL, with ap_rst high at a clock edge, set state=ACC, acc=0, counter=0, acc_out=0, acc_valid=0, acc_sat=0 and len_err=0, and hold p_ready=0 while ap_rst is high.
REQ-029 SHALL discard a partial frame or pending HOLD result when reset is asserted mid-operation, with no output on acc_valid.
REQ-030 SHALL give ap_rst priority over every simultaneous handshake.

Verification
REQ-031 Bench SHALL cover reset: ap_rst high 2 cycles -> all outputs 0; one cycle after ap_rst falls -> p_ready=1.
REQ-032 Bench SHALL cover basic sum: SHIFT_EN=1, terms 100, 200, -50 (last) -> acc_out=500, acc_sat=0, len_err=0, acc_valid one cycle after the last term.
REQ-033 Bench SHALL cover L_MULT saturation: single term 31'h4000_0000 with last -> acc_out=32'h7FFF_FFFF, acc_sat=1.
REQ-034 Bench SHALL cover add saturation: terms 31'h3FFF_FFFF, 31'h3FFF_FFFF (last) -> acc_out=32'h7FFF_FFFF, acc_sat=1; the same with 31'h4000_0001, 31'h4000_0001 -> 32'h8000_0000, acc_sat=1.
REQ-035 Bench SHALL cover backpressure: acc_ready low 5 cycles after close -> acc_out stable and p_ready=0 throughout; the next frame starts from acc=0 after the handshake.
REQ-036 Bench SHALL cover length overrun and reset: MAX_LEN=4, four terms of 1 without last -> acc_out=8, len_err=1; reset asserted after two terms of the next frame -> no acc_valid, and a fresh frame sums from 0.
